display_scanner: RTL
====================

# display_scanner

Drives the four-digit seven-segment display path: accepts a binary value over a load handshake, converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine, and time-multiplexes the digits onto the `tog`/`num` pair consumed by the segment/anode decoder. It sits between the datapath that produces the displayed number and the BCD segment decoder. It generates the digit-select and digit-value stream that the decoder receives.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each digit stays selected. Legal range 2 to 2^20; set to 4 in simulation.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `bin_in` input 14: unsigned value to display; values above 9999 are clamped.
- `load` input 1: request to convert `bin_in`; sampled only in IDLE.
- `busy` output 1: high while a conversion is in progress.
- `done` output 1: one-cycle pulse when the new digits are committed to the display.
- `ovf` output 1: the last accepted `bin_in` exceeded 9999.
- `tog` output 2: digit select. 0 = ones (rightmost), 1 = tens, 2 = hundreds, 3 = thousands.
- `num` output 4: BCD value of the selected digit, always 0 to 9.

## Operation
- Reset (async, `rst_n`=0): state IDLE; all four committed digits = 0; `tog`=0; refresh counter = 0; `busy`=0, `done`=0, `ovf`=0; therefore `num`=0.
- The conversion FSM has two states, IDLE and CONVERT.
  - IDLE with `load`=1: capture min(`bin_in`, 9999) into the shift register and clear the 16-bit BCD scratch. Set `ovf` = (`bin_in` > 9999). Clear the iteration counter. Go to CONVERT.
  - CONVERT: each cycle, first add 3 to every scratch nibble that is ≥5, then shift {scratch, shift register} left by 1. After the 14th iteration, copy the scratch into the committed digit register, pulse `done`, and go to IDLE.
  - `load` while in CONVERT is ignored; there is no queueing. `bin_in` is only sampled on the accepting edge.
- `ovf` holds its value until the next accepted load.
- The committed digits change only at commit, so the display keeps showing the previous value for the whole conversion.
- Refresh logic runs independently of the FSM:
  - The counter counts 0 to `REFRESH_DIV`-1 and wraps.
  - On each wrap, `tog` increments modulo 4 (3 goes to 0).
- `num` is a combinational mux of the committed digit indexed by `tog`.
  - A commit that lands mid-digit changes `num` immediately.
  - A commit does not disturb `tog` or the counter.
- Width rules: the scratch is 4 nibbles; clamping guarantees no nibble ever exceeds 9 after commit.

## Timing
- Load accepted at rising edge k: `busy`=1 from after edge k.
- Iterations occur at edges k+1 through k+14. The commit happens at edge k+14.
- After edge k+14: `busy`=0 and `done`=1 for exactly one cycle. New digits are visible on `num` in the same cycle.
- Load-to-done latency is 14 cycles. The next load can be accepted at edge k+15, the first edge seen in IDLE; that is the cycle in which `done`=1.
- `tog` changes on the edge where the counter wraps, i.e. every `REFRESH_DIV` cycles. The first change comes `REFRESH_DIV` edges after reset release.
- Reset asserted mid-conversion: the FSM immediately returns to IDLE, digits and `tog` clear, no `done` pulse is issued, and the partial result is discarded.
- `done` and `busy` are never both high.

## Test plan
- Reset, then idle for 20 cycles with `REFRESH_DIV`=4 → `tog` sequence 0,1,2,3,0 changing every 4 cycles; `num`=0 throughout; `busy`=`done`=`ovf`=0.
- Load `bin_in`=1234 → `busy` high for 14 cycles, `done` pulses once on the 14th cycle after acceptance; `num`=4,3,2,1 for `tog`=0,1,2,3; `ovf`=0.
- Load 9999, then load 16383 → first gives digits 9,9,9,9 with `ovf`=0; second gives digits 9,9,9,9 with `ovf`=1. Then load 0 → all digits 0 and `ovf`=0.
- Load 1234, pulse `load` with `bin_in`=5678 at cycle 5 of the conversion, then load 5678 in the `done` cycle → the mid-conversion request is ignored and 1234 is committed; the `done`-cycle request is accepted, and 5678 is committed 14 cycles later.
- Load 42 and assert `rst_n`=0 at cycle 7 of the conversion → all outputs return to reset values asynchronously; no `done` pulse; digits stay 0 after release.
- Load 907 while `tog`=2 mid-count → `num` switches from the old hundreds digit to 9 in the commit cycle without disturbing the `tog` cadence; leading thousands digit = 0.

Source files
------------

// File: rtl/display_scanner.sv
// display_scanner
//   Converts a 14-bit binary value to four BCD digits with a sequential
//   shift-add-3 (double-dabble) engine. It then time-multiplexes the committed
//   digits onto the tog/num pair for the segment/anode decoder.
//
// Parameters
//   REFRESH_DIV : clock cycles each digit stays selected (2 .. 2^20)
//
// Ports
//   clk    in   1  : clock, rising edge
//   rst_n  in   1  : asynchronous active-low reset
//   bin_in in  14  : unsigned value to display, clamped to 9999
//   load   in   1  : request a conversion, sampled only in IDLE
//   busy   out  1  : conversion in progress
//   done   out  1  : one-cycle pulse when new digits are committed
//   ovf    out  1  : last accepted bin_in exceeded 9999
//   tog    out  2  : digit select, 0 = ones .. 3 = thousands
//   num    out  4  : BCD value of the selected digit
module display_scanner #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] bin_in,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [1:0]  tog,
  output logic [3:0]  num
);

  localparam int              CNT_W   = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [13:0]      BIN_MAX = 14'd9999;
  localparam logic [3:0]       LAST_IT = 4'd13;

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t            state, state_nxt;
  logic              accept, last_iter;
  logic [3:0]        iter;
  logic [13:0]       shreg, shreg_nxt;
  logic [15:0]       scratch, scratch_adj, scratch_nxt;
  logic [15:0]       digits;
  logic [CNT_W-1:0]  cnt;

  // Saturate the input to the largest four-digit decimal value.
  function automatic logic [13:0] clamp_bin(input logic [13:0] v);
    return (v > BIN_MAX) ? BIN_MAX : v;
  endfunction

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift,
  // so that it carries correctly into the next decimal digit.
  function automatic logic [15:0] add3_nibbles(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 4; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // FSM next-state and strobes
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_iter = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          accept    = 1'b1;
          state_nxt = CONVERT;
        end
      end
      CONVERT: begin
        if (iter == LAST_IT) begin
          last_iter = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Shift-add-3 step: {scratch, shreg} shifted left by one after correction.
  always_comb begin
    scratch_adj = add3_nibbles(scratch);
    scratch_nxt = {scratch_adj[14:0], shreg[13]};
    shreg_nxt   = {shreg[12:0], 1'b0};
  end

  // Conversion control and committed digits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter   <= '0;
      done   <= 1'b0;
      ovf    <= 1'b0;
      digits <= '0;
    end else begin
      done <= last_iter;
      if (accept) begin
        iter <= '0;
        ovf  <= (bin_in > BIN_MAX);
      end else if (state == CONVERT) begin
        iter <= iter + 4'd1;
      end
      if (last_iter) digits <= scratch_nxt;
    end
  end

  // Conversion datapath: only meaningful between accept and commit, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg   <= clamp_bin(bin_in);
      scratch <= '0;
    end else if (state == CONVERT) begin
      shreg   <= shreg_nxt;
      scratch <= scratch_nxt;
    end
  end

  // Refresh counter and digit select, independent of the conversion FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      tog <= 2'd0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      tog <= tog + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign busy = (state == CONVERT);

  always_comb begin
    num = digits[3:0];
    case (tog)
      2'd0: num = digits[3:0];
      2'd1: num = digits[7:4];
      2'd2: num = digits[11:8];
      2'd3: num = digits[15:12];
      default: num = digits[3:0];
    endcase
  end

endmodule
